// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// word geometry and byte-address to word-index conversion.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data RAM with byte-enable synchronous write and registered read.
// Each byte lane is its own narrow memory so the write mask maps onto separate RAM columns.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [BYTES_PER_WORD-1:0] be,
    input  logic [AW-1:0]             waddr,
    input  logic [31:0]               wdata,
    input  logic                      re,
    input  logic [AW-1:0]             raddr,
    output logic [31:0]               rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[waddr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    q_reg <= mem[raddr];
                end
            end

            assign rdata[8*gi +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the processor data port: accepts one load/store at a time,
// waits LATENCY cycles, then pulses ready with read data and an address error flag.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        ready_reg;
    logic        err_reg;
    logic        rd_valid_reg;

    logic        capture;
    logic        go_resp;
    logic        eff_we;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [3:0]  eff_be;
    logic [29:0] eff_idx;
    logic        eff_err;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_q;

    // With LATENCY=0 the RAM access happens on the accepting edge, so the
    // transaction fields must come straight from the ports while still in IDLE.
    always_comb begin
        if (state_reg == IDLE) begin
            eff_we    = we;
            eff_addr  = addr;
            eff_wdata = wdata;
            eff_be    = be;
        end else begin
            eff_we    = we_reg;
            eff_addr  = addr_reg;
            eff_wdata = wdata_reg;
            eff_be    = be_reg;
        end
        eff_idx = word_index(eff_addr);
        eff_err = (eff_addr[1:0] != 2'b00) || (eff_idx >= DEPTH_W);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        go_resp    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture  = 1'b1;
                    cnt_next = LAT;
                    if (LAT == 4'd0) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Gating with reset keeps a store abandoned mid-wait out of the RAM.
    assign ram_we = go_resp && eff_we && !eff_err && !reset;
    assign ram_re = go_resp && !eff_we && !reset;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .be    (eff_be),
        .waddr (eff_idx[AW-1:0]),
        .wdata (eff_wdata),
        .re    (ram_re),
        .raddr (eff_idx[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            be_reg       <= 4'd0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                be_reg    <= be;
            end
            ready_reg    <= go_resp;
            err_reg      <= go_resp && eff_err;
            rd_valid_reg <= go_resp && !eff_we && !eff_err;
        end
    end

    assign ready = ready_reg;
    assign err   = err_reg;
    assign rdata = rd_valid_reg ? ram_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
// Drivers queue expected responses; negedge monitors pop and compare on every ready pulse.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst2, rst0;
    logic        req2, req0;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready2, err2, ready0, err0;
    logic [31:0] rdata2, rdata0;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] name;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (rst2),
        .req   (req2),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .ready (ready2),
        .rdata (rdata2),
        .err   (err2)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .req   (req0),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .ready (ready0),
        .rdata (rdata0),
        .err   (err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2 unexpected_ready: cycle %0d got ready=1 expected 0", cyc);
            end else begin
                e = q2.pop_front();
                $display("txn lat2 %0s: cycle=%0d rdata=%h err=%0d", e.name, cyc, rdata2, err2);
                check($sformatf("lat2 %0s rdata", e.name), rdata2, e.rdata);
                check($sformatf("lat2 %0s err", e.name), 32'(err2), 32'(e.err));
                check($sformatf("lat2 %0s cycle", e.name), 32'(cyc), 32'(e.cyc));
            end
        end
        if (ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected_ready: cycle %0d got ready=1 expected 0", cyc);
            end else begin
                e = q0.pop_front();
                $display("txn lat0 %0s: cycle=%0d rdata=%h err=%0d", e.name, cyc, rdata0, err0);
                check($sformatf("lat0 %0s rdata", e.name), rdata0, e.rdata);
                check($sformatf("lat0 %0s err", e.name), 32'(err0), 32'(e.err));
                check($sformatf("lat0 %0s cycle", e.name), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_drain(input int which);
        int left;
        int pending;
        left    = 40;
        pending = (which == 0) ? q0.size() : q2.size();
        while (left > 0 && pending > 0) begin
            @(posedge clk);
            left--;
            pending = (which == 0) ? q0.size() : q2.size();
        end
        checks++;
        if (pending > 0) begin
            errors++;
            $display("FAIL drain_timeout dut%0d: got %0d pending responses expected 0", which, pending);
            if (which == 0) q0.delete();
            else q2.delete();
        end
        repeat (6) @(posedge clk);
    endtask

    // Raise req for 'hold' cycles starting at cycle n; expect nexp responses
    // spaced LATENCY+2 apart, the first at n+1+LATENCY.
    task automatic drive(input int which, input logic [63:0] name, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         input int hold, input int nexp,
                         input logic [31:0] er, input logic ee);
        int   lat;
        int   n;
        exp_t e;
        lat = (which == 0) ? 0 : 2;
        @(posedge clk);
        #1;
        n = cyc;
        for (int k = 0; k < nexp; k++) begin
            e.name  = name;
            e.rdata = er;
            e.err   = ee;
            e.cyc   = n + 1 + lat + k * (lat + 2);
            if (which == 0) q0.push_back(e);
            else q2.push_back(e);
        end
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        if (which == 0) req0 = 1'b1;
        else req2 = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        req2 = 1'b0;
        wait_drain(which);
    endtask

    task automatic txn2(input logic [63:0] name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] er, input logic ee);
        drive(2, name, w, a, d, b, 3, 1, er, ee);
    endtask

    initial begin
        rst2  = 1'b1;
        rst0  = 1'b1;
        req2  = 1'b0;
        req0  = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        be    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready2", 32'(ready2), 32'd0);
        check("reset err2", 32'(err2), 32'd0);
        check("reset rdata2", rdata2, 32'd0);
        check("reset ready0", 32'(ready0), 32'd0);
        check("reset err0", 32'(err0), 32'd0);
        check("reset rdata0", rdata0, 32'd0);
        rst2 = 1'b0;
        rst0 = 1'b0;

        // Store/load, byte mask, zero mask
        txn2("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn2("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        txn2("st10b0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        txn2("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
        txn2("st10be0", 1'b1, 32'h10, 32'h55555555, 4'b0000, 32'h0, 1'b0);
        txn2("ld10c", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Address errors
        txn2("ld12mis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
        txn2("ld100", 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
        txn2("st00", 1'b1, 32'h0, 32'h11223344, 4'hF, 32'h0, 1'b0);
        txn2("st100", 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn2("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h11223344, 1'b0);
        txn2("st21mis", 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);

        // req dropped in WAIT, and req held through RESP
        drive(2, "ld10drop", 1'b0, 32'h10, 32'h0, 4'h0, 1, 1, 32'hDEADBEAA, 1'b0);
        drive(2, "ld00hold", 1'b0, 32'h0, 32'h0, 4'h0, 4, 1, 32'h11223344, 1'b0);

        // Reset while a store sits in WAIT
        txn2("st20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h12345678;
        be    = 4'hF;
        req2  = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        check("midreset ready2", 32'(ready2), 32'd0);
        check("midreset err2", 32'(err2), 32'd0);
        check("midreset rdata2", rdata2, 32'd0);
        repeat (8) @(posedge clk);
        txn2("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

        // LATENCY=0: single store then back-to-back loads every 2 cycles
        drive(0, "st08", 1'b1, 32'h8, 32'hA5A55A5A, 4'hF, 1, 1, 32'h0, 1'b0);
        drive(0, "ld08b2b", 1'b0, 32'h8, 32'h0, 4'h0, 6, 3, 32'hA5A55A5A, 1'b0);
        drive(0, "ld100", 1'b0, 32'h100, 32'h0, 4'h0, 1, 1, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
